seq_div: RTL

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/div_pkg.sv | 14 +
 rtl/div_abs.sv | 18 +
 rtl/seq_div.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: default operand width and
// the FSM state encoding used by seq_div.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to apply the sign correction to quotient and remainder.
module div_abs
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  // Pass the value through, or its negation when neg_i is set.
  always_comb begin
    res_o = neg_i ? ('0 - val_i) : val_i;
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle non-restoring divider, signed or unsigned, one quotient bit per
// clock. Result is C = {remainder, quotient}; divide-by-zero short-circuits to
// DONE with quotient all-ones and the dividend as remainder.
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [2*WIDTH-1:0] C
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       r_q, r_d;      // signed partial remainder, one extra bit
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;      // divisor magnitude
  logic                 sa_q, sa_d;    // dividend was negative (signed mode)
  logic                 sb_q, sb_d;    // divisor was negative (signed mode)
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       m_ext, r_sh, r_step;
  logic [WIDTH-1:0]     q_step;
  logic [WIDTH-1:0]     rem_mag, q_fix, r_fix;

  div_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i (A),
    .neg_i (sgn & A[WIDTH-1]),
    .res_o (a_mag)
  );

  div_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i (B),
    .neg_i (sgn & B[WIDTH-1]),
    .res_o (b_mag)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_q (
    .val_i (q_q),
    .neg_i (sa_q ^ sb_q),
    .res_o (q_fix)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_r (
    .val_i (rem_mag),
    .neg_i (sa_q),
    .res_o (r_fix)
  );

  // One non-restoring step and the final remainder restore.
  // The shifted remainder may wrap in WIDTH+1 bits, but the add/sub result
  // always lands in [-M, M), and the direction is chosen from the pre-shift
  // sign, so the wrap is harmless. The restore keeps only the low WIDTH bits
  // because the corrected remainder is known to lie in [0, M).
  always_comb begin
    m_ext   = {1'b0, m_q};
    r_sh    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_step  = r_q[WIDTH] ? (r_sh + m_ext) : (r_sh - m_ext);
    q_step  = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
    rem_mag = r_q[WIDTH] ? (r_q[WIDTH-1:0] + m_q) : r_q[WIDTH-1:0];
  end

  // Next-state and datapath control for IDLE/CALC/FIX/DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (B == '0) begin
            c_d     = {A, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            r_d     = '0;
            q_d     = a_mag;
            m_d     = b_mag;
            sa_d    = sgn & A[WIDTH-1];
            sb_d    = sgn & B[WIDTH-1];
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        c_d     = {r_fix, q_fix};
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      c_q     <= c_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign C    = c_q;

endmodule
